// File: rtl/timer_compare_datapath.sv
// Timer-compare datapath: A/B/R registers, step counter,
// button pulse synchronizer and alarm ringer.
module timer_compare_datapath #(
  parameter int W        = 6,
  parameter int MOD_VAL  = 60,
  parameter int C_TERM   = 7,
  parameter int CW       = 3,
  parameter int RING_CYC = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         btn_set,
  input  logic [W-1:0] time_in,
  input  logic [W-1:0] set_in,
  input  logic [1:0]   s,
  input  logic         Kc,
  input  logic         La,
  input  logic         Lb,
  input  logic         Ea,
  input  logic         Lr,
  input  logic         Er,
  input  logic         Cc,
  input  logic         M,
  output logic         Ts,
  output logic         c7,
  output logic         Az,
  output logic         alarm,
  output logic [W-1:0] a_q
);

  localparam int RW = (RING_CYC > 1) ? $clog2(RING_CYC) : 1;
  localparam logic [W:0]    MOD_W  = (W+1)'(MOD_VAL);
  localparam logic [CW-1:0] CTERM  = CW'(C_TERM);
  localparam logic [RW-1:0] RLOAD  = RW'(RING_CYC - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RING = 1'b1
  } ring_e;

  logic [W-1:0]  b_q, r_q;
  logic [W-1:0]  a_d, b_d, r_d;
  logic [W:0]    sum;
  logic [W:0]    sum_wrap;
  logic [CW-1:0] c_q, c_d;
  logic [RW-1:0] ring_cnt_q;
  ring_e         ring_q;
  logic          sync1_q, sync2_q, sync3_q;

  assign sum      = {1'b0, a_q} + {1'b0, b_q};
  assign sum_wrap = (sum >= MOD_W) ? (sum - MOD_W) : sum;
  assign c7       = (c_q == CTERM);

  // Next-state selection for A, B, R and the step counter
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    r_d = r_q;
    c_d = c_q;
    if (La) begin
      unique case (s)
        2'b00:   a_d = time_in;
        2'b01:   a_d = set_in;
        2'b10:   a_d = sum_wrap[W-1:0];
        default: a_d = '0;
      endcase
    end else if (Ea) begin
      a_d = (a_q == '0) ? '0 : a_q - 1'b1;
    end
    if (Lb) b_d = set_in;
    if (Lr)      r_d = '0;
    else if (Er) r_d = time_in;
    if (Kc)      c_d = '0;
    else if (Cc) c_d = c_q + 1'b1;
  end

  // Datapath registers and the compare flag built from next values
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      r_q <= '0;
      c_q <= '0;
      Az  <= 1'b0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      r_q <= r_d;
      c_q <= c_d;
      Az  <= (a_d == r_d);
    end
  end

  // Two-flop synchronizer plus registered rising-edge pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      Ts      <= 1'b0;
    end else begin
      sync1_q <= btn_set;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      Ts      <= sync2_q & ~sync3_q;
    end
  end

  // Ringer FSM: M (re)loads the count, alarm holds until it runs out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ring_q     <= IDLE;
      ring_cnt_q <= '0;
      alarm      <= 1'b0;
    end else begin
      unique case (ring_q)
        IDLE: begin
          if (M) begin
            ring_q     <= RING;
            ring_cnt_q <= RLOAD;
            alarm      <= 1'b1;
          end
        end
        RING: begin
          if (M) begin
            ring_cnt_q <= RLOAD;
          end else if (ring_cnt_q == '0) begin
            ring_q <= IDLE;
            alarm  <= 1'b0;
          end else begin
            ring_cnt_q <= ring_cnt_q - 1'b1;
          end
        end
        default: begin
          ring_q <= IDLE;
          alarm  <= 1'b0;
        end
      endcase
    end
  end

endmodule
